// File: rtl/cache_mem_responder_if.sv
// Request/response handshake bus between the data cache (master) and the memory responder (slave).
interface cache_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_addr_mode;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr_mode, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr_mode, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/cache_mem_responder.sv
// Memory-side responder for data-cache fills and write-through stores, fixed-latency responses.
// Optional macro CACHE_MEM_BACKPRESSURE_EN: hold resp_valid until resp_ready instead of pulsing.
module cache_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cache_mem_responder_if.slave bus
);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [1:0]            mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [IdxW-1:0]       idx;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] wlanes;
    logic [DATA_WIDTH-1:0] merged;
    logic [3:0]            be;
    logic                  is_byte, is_half, oor, misaligned, mem_we;

    // Access decode; mode bit 2 (unsigned) only matters to the cache's lane extraction.
    always_comb begin
        idx        = addr_q[IdxW+1:2];
        cur_word   = mem_q[idx];
        is_byte    = (mode_q == 2'b00);
        is_half    = (mode_q == 2'b01);
        oor        = ((addr_q >> (IdxW + 2)) != '0);
        misaligned = is_half ? addr_q[0] : (!is_byte && (addr_q[1:0] != 2'b00));
        if (is_byte) begin
            be     = 4'b0001 << addr_q[1:0];
            wlanes = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            be     = addr_q[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{wdata_q[15:0]}};
        end else begin
            be     = 4'b1111;
            wlanes = wdata_q;
        end
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = wlanes[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mode_d      = mode_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        mem_we      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    mode_d  = bus.req_addr_mode[1:0];
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = CntW'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                    if (oor) begin
                        resp_data_d = '0;
                        resp_err_d  = 1'b1;
                    end else if (misaligned) begin
                        resp_data_d = cur_word;
                        resp_err_d  = 1'b1;
                    end else begin
                        mem_we      = we_q;
                        resp_data_d = we_q ? merged : cur_word;
                        resp_err_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
`ifdef CACHE_MEM_BACKPRESSURE_EN
                if (bus.resp_ready) state_d = StIdle;
`else
                state_d = StIdle;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            mode_q      <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Array is deliberately unreset; mem_we can only fire from StWait, so reset blocks the write.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= merged;
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder (default parameters, LATENCY = 2).
module tb_cache_mem_responder;
    localparam int unsigned LAT   = 2;
    localparam int unsigned WORDS = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cache_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    cache_mem_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_WORDS (WORDS),
        .LATENCY   (LAT)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One request/response; lat counts edges from acceptance to resp_valid observed.
    task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] data,
                          output logic err, output int lat);
        int w;
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_we        = we;
        bus.req_addr_mode = mode;
        bus.req_addr      = addr;
        bus.req_wdata     = wdata;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) check_eq("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = bus.resp_data;
        err  = bus.resp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input string tag, input logic we, input logic [2:0] mode,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] d;
        logic        e;
        int          l;
        do_req(we, mode, addr, wdata, d, e, l);
        check_eq({tag, "_data"}, d, exp_data);
        check_eq({tag, "_err"}, 32'(e), 32'(exp_err));
        check_eq({tag, "_lat"}, 32'(l), 32'(LAT));
    endtask

    logic        resp_seen;
    logic [31:0] d0;
    logic        e0;
    int          l0;
    int          resp_cyc [2];
    int          nresp;

    initial begin
        bus.req_valid     = 1'b0;
        bus.req_we        = 1'b0;
        bus.req_addr_mode = 3'b010;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.resp_ready    = 1'b1;

        #3;
        check_eq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("rst_resp_data", bus.resp_data, 32'd0);
        check_eq("rst_resp_err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then read
        xfer("w_store", 1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        check_eq("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("post_hs_hold_data", bus.resp_data, 32'hDEADBEEF);
        xfer("w_read", 1'b0, 3'b010, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte and half merge
        xfer("w_base", 1'b1, 3'b010, 32'h80, 32'h11223344, 32'h11223344, 1'b0);
        xfer("b_merge", 1'b1, 3'b000, 32'h82, 32'h000000AA, 32'h11AA3344, 1'b0);
        xfer("h_merge", 1'b1, 3'b001, 32'h80, 32'h0000BEEF, 32'h11AABEEF, 1'b0);

        // Error cases
        xfer("h_misal", 1'b1, 3'b001, 32'h81, 32'h00001234, 32'h11AABEEF, 1'b1);
        xfer("h_misal_rd", 1'b0, 3'b010, 32'h80, 32'h0, 32'h11AABEEF, 1'b0);
        xfer("oor_read", 1'b0, 3'b010, 32'(4 * WORDS), 32'h0, 32'h0, 1'b1);
        xfer("w0_base", 1'b1, 3'b010, 32'h0, 32'h00000055, 32'h00000055, 1'b0);
        xfer("oor_store", 1'b1, 3'b010, 32'(4 * WORDS), 32'hCAFEF00D, 32'h0, 1'b1);
        xfer("oor_noalias", 1'b0, 3'b010, 32'h0, 32'h0, 32'h00000055, 1'b0);

        // Unsigned modes, upper lanes, odd mode code, word misalignment
        xfer("bu_hi", 1'b1, 3'b100, 32'h43, 32'hFFFFFF77, 32'h77ADBEEF, 1'b0);
        xfer("hu_hi", 1'b1, 3'b101, 32'h42, 32'hFFFF1111, 32'h1111BEEF, 1'b0);
        xfer("mode3_w", 1'b1, 3'b011, 32'h44, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0);
        xfer("w_misal", 1'b1, 3'b010, 32'h46, 32'h12345678, 32'h0BADCAFE, 1'b1);
        xfer("b_rd_word", 1'b0, 3'b000, 32'h45, 32'h0, 32'h0BADCAFE, 1'b0);

        // Reset during WAIT drops the store
        xfer("rst_base", 1'b1, 3'b010, 32'h10, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b1;
        bus.req_addr_mode = 3'b010;
        bus.req_addr      = 32'h10;
        bus.req_wdata     = 32'h12345678;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_eq("acc_req_ready_low", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("midrst_resp_data", bus.resp_data, 32'd0);
        resp_seen = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen = 1'b1;
        end
        check_eq("midrst_no_resp", 32'(resp_seen), 32'd0);
        xfer("midrst_rd", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5A5A5A5, 1'b0);

        // Back-to-back reads with req_valid held
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b0;
        bus.req_addr_mode = 3'b010;
        bus.req_addr      = 32'h40;
        nresp = 0;
        for (int c = 0; c < 30 && nresp < 2; c++) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) begin
                resp_cyc[nresp] = c;
                nresp++;
                if (nresp == 2) bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        check_eq("b2b_count", 32'(nresp), 32'd2);
        if (nresp == 2) check_eq("b2b_spacing", 32'(resp_cyc[1] - resp_cyc[0]), 32'(LAT + 2));
        @(posedge clk);
        #1;

        // Response with resp_ready low
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid     = 1'b1;
        bus.req_we        = 1'b0;
        bus.req_addr_mode = 3'b010;
        bus.req_addr      = 32'h80;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        l0 = 0;
        while (!bus.resp_valid && l0 < 20) begin
            @(posedge clk);
            #1;
            l0++;
        end
        check_eq("bp_lat", 32'(l0), 32'(LAT));
        check_eq("bp_data", bus.resp_data, 32'h11AABEEF);
`ifdef CACHE_MEM_BACKPRESSURE_EN
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_eq("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            check_eq("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            check_eq("bp_hold_data", bus.resp_data, 32'h11AABEEF);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_release_valid", 32'(bus.resp_valid), 32'd0);
        check_eq("bp_release_ready", 32'(bus.req_ready), 32'd1);
`else
        @(posedge clk);
        #1;
        check_eq("pulse_valid_drop", 32'(bus.resp_valid), 32'd0);
        check_eq("pulse_req_ready", 32'(bus.req_ready), 32'd1);
        check_eq("pulse_hold_data", bus.resp_data, 32'h11AABEEF);
        bus.resp_ready = 1'b1;
`endif
        do_req(1'b0, 3'b010, 32'h44, 32'h0, d0, e0, l0);
        check_eq("final_rd", d0, 32'h0BADCAFE);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Memory-side responder that serves the data cache's line-fill reads and write-through stores over a valid/ready request and response handshake. It holds the backing word array, applies byte, halfword or word stores, and returns the full aligned 32-bit word after a programmable latency. It sits between the set-associative data cache and the rest of the memory system, replacing the cache's direct combinational tie to data memory.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: word width; fixed at 32.
- `MEM_WORDS`, 1024: backing array depth in words; power of two.
- `LATENCY`, 2: cycles from request acceptance to `resp_valid`; must be ≥1.

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: responder can accept a request.
- `req_we` input 1: 1 = store, 0 = fill read.
- `req_addr_mode` input 3: 000 = B, 100 = BU, 001 = H, 101 = HU, 010 = W; other codes are treated as W.
- `req_addr` input ADDR_WIDTH: byte address.
- `req_wdata` input 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` output 1: response present.
- `resp_ready` input 1: requester accepts the response.
- `resp_data` output 32: full aligned word at `req_addr[31:2]`, as stored after any write.
- `resp_err` output 1: request was misaligned or out of range.

## Operation
- FSM with three states.
  - IDLE: `req_ready` = 1. On `req_valid`, latch we, mode, addr and wdata, load counter = `LATENCY`-1, and go to WAIT.
  - WAIT: if counter = 0, perform the access and go to RESP; otherwise decrement the counter.
  - RESP: `resp_valid` = 1. On `resp_ready`, go to IDLE.
- Word index = addr[$clog2(MEM_WORDS)+1:2].
- Out of range (addr[ADDR_WIDTH-1:2] ≥ `MEM_WORDS`): `resp_err` = 1, `resp_data` = 0, no write.
- Misaligned (H/HU with addr[0] = 1, or W with addr[1:0] ≠ 0): `resp_err` = 1, no write, `resp_data` = the current aligned word.
- Store byte enables: B/BU write lane addr[1:0] with wdata[7:0]. H/HU write lanes {addr[1],0} and {addr[1],1} with wdata[15:0]. W writes all four lanes.
- Stores return the post-write word. Reads return the whole word regardless of mode; the cache performs lane extraction and sign extension.
- The storage array has no reset. Its contents are undefined until written, unless preloaded (see Configuration).
- Only one request is outstanding at a time. `req_ready` is low in WAIT and RESP.

## Timing
- Reset values: `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `resp_err` = 0, state = IDLE, counter = 0.
- A request accepted at edge k produces `resp_valid` high from edge k+`LATENCY`. The array write and the `resp_data`/`resp_err` registration happen at that same edge.
- `resp_data` and `resp_err` are stable while `resp_valid` = 1. They hold their last value after the handshake.
- A response handshake at edge m raises `req_ready` from edge m+1. Best throughput is one request per `LATENCY`+2 cycles.
- Reset asserted mid-operation drops the outstanding request. If it is asserted before the access edge, the store is not performed. Outputs return to reset values immediately.
- `req_valid` deasserting while `req_ready` = 0 has no effect. Requests are not required to stay stable beyond the acceptance edge.

## Configuration
- `CACHE_MEM_BACKPRESSURE_EN` defined: RESP holds `resp_valid` until `resp_ready` = 1.
- `CACHE_MEM_BACKPRESSURE_EN` undefined: `resp_ready` is ignored. `resp_valid` is a single-cycle pulse and RESP always returns to IDLE on the next edge.

## Test plan
- Word store then read: W store 0xDEADBEEF to 0x40, then read 0x40. Both responses carry `resp_data` = 0xDEADBEEF and `resp_err` = 0, with `resp_valid` exactly `LATENCY` cycles after acceptance.
- Byte and half merge: over word 0x11223344 at 0x80, B store 0xAA to 0x82 gives 0x11AA3344. Then H store 0xBEEF to 0x80 gives 0x11AABEEF.
- Errors: H store to 0x81 gives `resp_err` = 1 and the word is unchanged. Read at byte address 4*`MEM_WORDS` gives `resp_err` = 1 and `resp_data` = 0.
- Backpressure (macro defined): hold `resp_ready` = 0 for 5 cycles. `resp_valid` stays 1 and `req_ready` stays 0. `req_ready` rises one cycle after the handshake.
- Reset mid-WAIT (`LATENCY` = 4): W store 0x12345678 to 0x10 with a pulse on `rst_n` one cycle after acceptance. No response is produced, and a following read of 0x10 returns the prior contents.
- `LATENCY` = 1 back-to-back: two reads issued as soon as `req_ready` allows give responses 3 cycles apart.
